// File: rtl/uart_frame_gen.sv
// Multi-character UART frame transmitter: start, LSB-first data, optional parity, 1/2 stop bits.
// Optional macro UART_FRAME_GEN_GAP_EN adds GAP_BITS idle bit times between characters.
module uart_frame_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BYTES  = 4
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [5:0]                         PRESCALE,
   input  logic                               PAR_EN,
   input  logic                               PAR_TYP,
   input  logic                               STOP2,
`ifdef UART_FRAME_GEN_GAP_EN
   input  logic [3:0]                         GAP_BITS,
`endif
   input  logic [DATA_WIDTH*MAX_BYTES-1:0]    FRAME_DATA,
   input  logic [$clog2(MAX_BYTES+1)-1:0]     FRAME_LEN,
   input  logic                               FRAME_VLD,
   output logic                               TX_OUT,
   output logic                               BUSY,
   output logic                               BYTE_DONE,
   output logic                               FRAME_DONE
);

   localparam int LW = $clog2(MAX_BYTES+1);
   localparam int BW = $clog2(DATA_WIDTH+1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;

   typedef struct packed {
      logic [5:0] ps;
      logic       par_en;
      logic       par_typ;
      logic       stop2;
   } cfg_t;

   state_t                            state_q, state_d;
   cfg_t                              cfg_q;
   logic [DATA_WIDTH*MAX_BYTES-1:0]   data_q;
   logic [DATA_WIDTH-1:0]             sh_q;
   logic [LW-1:0]                     bytes_left_q;
   logic [LW-1:0]                     len_cl;
   logic [5:0]                        cnt_q;
   logic [BW-1:0]                     bit_idx_q;
   logic                              stop_idx_q;

   logic accept, bit_end, last_bit, last_stop, last_byte, par_bit;
   logic gap_req, last_gap;
   logic tx_bit, byte_done, frame_done;

`ifdef UART_FRAME_GEN_GAP_EN
   logic [3:0] gap_q, gap_cnt_q;
   assign gap_req  = (gap_q != 4'd0);
   assign last_gap = (gap_cnt_q == gap_q - 4'd1);
`else
   assign gap_req  = 1'b0;
   assign last_gap = 1'b1;
`endif

   assign len_cl    = (FRAME_LEN > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : FRAME_LEN;
   assign accept    = FRAME_VLD && (state_q == S_IDLE) && (FRAME_LEN != '0);
   assign bit_end   = (cnt_q == cfg_q.ps - 6'd1);
   assign last_bit  = (bit_idx_q == BW'(DATA_WIDTH-1));
   assign last_stop = (stop_idx_q == cfg_q.stop2);
   assign last_byte = (bytes_left_q == LW'(1));
   // parity always covers the unshifted current character at the bottom of data_q
   assign par_bit   = (^data_q[DATA_WIDTH-1:0]) ^ cfg_q.par_typ;

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      tx_bit     = 1'b1;
      byte_done  = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_START;
         end
         S_START: begin
            tx_bit = 1'b0;
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            tx_bit = sh_q[0];
            if (bit_end && last_bit) state_d = cfg_q.par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            tx_bit = par_bit;
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (bit_end && last_stop) begin
               byte_done = 1'b1;
               if (last_byte) begin
                  frame_done = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  state_d = gap_req ? S_GAP : S_START;
               end
            end
         end
         S_GAP: begin
            if (bit_end && last_gap) state_d = S_START;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cfg_q        <= '0;
         data_q       <= '0;
         sh_q         <= '0;
         bytes_left_q <= '0;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         stop_idx_q   <= 1'b0;
`ifdef UART_FRAME_GEN_GAP_EN
         gap_q        <= '0;
         gap_cnt_q    <= '0;
`endif
      end else begin
         if (accept) begin
            cfg_q.ps      <= (PRESCALE == 6'd0) ? 6'd1 : PRESCALE;
            cfg_q.par_en  <= PAR_EN;
            cfg_q.par_typ <= PAR_TYP;
            cfg_q.stop2   <= STOP2;
            data_q        <= FRAME_DATA;
            bytes_left_q  <= len_cl;
`ifdef UART_FRAME_GEN_GAP_EN
            gap_q         <= GAP_BITS;
            gap_cnt_q     <= '0;
`endif
         end

         // cnt_q paces every bit time, including gap bits
         if (state_q == S_IDLE || bit_end) cnt_q <= '0;
         else                              cnt_q <= cnt_q + 6'd1;

         if (state_q == S_START && bit_end) sh_q <= data_q[DATA_WIDTH-1:0];
         if (state_q == S_DATA && bit_end) begin
            sh_q      <= sh_q >> 1;
            bit_idx_q <= last_bit ? '0 : bit_idx_q + BW'(1);
         end

         if (state_q == S_STOP && bit_end) stop_idx_q <= last_stop ? 1'b0 : 1'b1;

         if (byte_done) begin
            data_q       <= data_q >> DATA_WIDTH;
            bytes_left_q <= bytes_left_q - LW'(1);
         end

`ifdef UART_FRAME_GEN_GAP_EN
         if (state_q == S_GAP && bit_end) gap_cnt_q <= last_gap ? '0 : gap_cnt_q + 4'd1;
`endif
      end
   end

   assign TX_OUT     = tx_bit;
   assign BUSY       = (state_q != S_IDLE);
   assign BYTE_DONE  = byte_done;
   assign FRAME_DONE = frame_done;

endmodule

// File: tb/tb_uart_frame_gen.sv
// Randomized bench for uart_frame_gen: a per-cycle waveform model built from bit lists.
module tb_uart_frame_gen;

   logic        CLK = 1'b0;
   logic        RST;
   logic [5:0]  PRESCALE;
   logic        PAR_EN, PAR_TYP, STOP2;
   logic [31:0] FRAME_DATA;
   logic [2:0]  FRAME_LEN;
   logic        FRAME_VLD;
   logic        TX_OUT, BUSY, BYTE_DONE, FRAME_DONE;
`ifdef UART_FRAME_GEN_GAP_EN
   logic [3:0]  GAP_BITS;
`endif

   int n_chk = 0;
   int n_err = 0;

   uart_frame_gen #(.DATA_WIDTH(8), .MAX_BYTES(4)) dut (
      .CLK(CLK), .RST(RST), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .STOP2(STOP2),
`ifdef UART_FRAME_GEN_GAP_EN
      .GAP_BITS(GAP_BITS),
`endif
      .FRAME_DATA(FRAME_DATA), .FRAME_LEN(FRAME_LEN), .FRAME_VLD(FRAME_VLD),
      .TX_OUT(TX_OUT), .BUSY(BUSY), .BYTE_DONE(BYTE_DONE), .FRAME_DONE(FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drives one request, then checks every cycle of the frame against a waveform
   // built from the character bit lists. Returns the observed FRAME_DONE cycle.
   task automatic run_frame(input logic [31:0] d, input int len, input int ps,
                            input bit pe, input bit pt, input bit s2, input int gap,
                            input bit poke, output int fd_cyc);
      bit exp_tx[$], exp_bd[$], exp_fd[$];
      int p, n, poke_at, eff_len, gap_eff;
      bit bits[$];
      logic [7:0] ch;
      p       = (ps == 0) ? 1 : ps;
      eff_len = (len > 4) ? 4 : len;
`ifdef UART_FRAME_GEN_GAP_EN
      gap_eff  = gap;
      GAP_BITS = gap[3:0];
`else
      gap_eff  = 0;
`endif
      for (int b = 0; b < eff_len; b++) begin
         ch = d[b*8 +: 8];
         bits = {};
         bits.push_back(1'b0);
         for (int k = 0; k < 8; k++) bits.push_back(ch[k]);
         if (pe) bits.push_back((^ch) ^ pt);
         bits.push_back(1'b1);
         if (s2) bits.push_back(1'b1);
         for (int j = 0; j < bits.size(); j++)
            for (int c = 0; c < p; c++) begin
               exp_tx.push_back(bits[j]);
               exp_bd.push_back(j == bits.size()-1 && c == p-1);
               exp_fd.push_back(j == bits.size()-1 && c == p-1 && b == eff_len-1);
            end
         if (b != eff_len-1)
            for (int c = 0; c < gap_eff*p; c++) begin
               exp_tx.push_back(1'b1); exp_bd.push_back(1'b0); exp_fd.push_back(1'b0);
            end
      end
      n = exp_tx.size();
      FRAME_DATA = d; FRAME_LEN = len[2:0]; PRESCALE = ps[5:0];
      PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; FRAME_VLD = 1'b1;
      @(posedge CLK); #1 FRAME_VLD = 1'b0;
      poke_at = poke ? $urandom_range(1, n-1) : 0;
      fd_cyc = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         chk("tx", {31'b0, TX_OUT}, {31'b0, exp_tx[i]});
         chk("busy", {31'b0, BUSY}, 32'd1);
         chk("byte_done", {31'b0, BYTE_DONE}, {31'b0, exp_bd[i]});
         chk("frame_done", {31'b0, FRAME_DONE}, {31'b0, exp_fd[i]});
         if (FRAME_DONE && fd_cyc < 0) fd_cyc = i + 1;
         if (poke && i + 1 == poke_at) begin
            FRAME_VLD = 1'b1; FRAME_DATA = $urandom; FRAME_LEN = 3'($urandom_range(1, 7));
            PRESCALE = 6'($urandom); PAR_EN = ~pe; STOP2 = ~s2;
         end else FRAME_VLD = 1'b0;
      end
      @(negedge CLK);
      chk("idle_busy", {31'b0, BUSY}, 32'd0);
      chk("idle_tx", {31'b0, TX_OUT}, 32'd1);
   endtask

   initial begin
      int fd;
      RST = 1'b1; FRAME_VLD = 1'b0; FRAME_DATA = '0; FRAME_LEN = '0;
      PRESCALE = 6'd1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
`ifdef UART_FRAME_GEN_GAP_EN
      GAP_BITS = '0;
`endif
      repeat (3) @(negedge CLK);
      chk("rst_tx", {31'b0, TX_OUT}, 32'd1);
      chk("rst_busy", {31'b0, BUSY}, 32'd0);
      chk("rst_bd", {31'b0, BYTE_DONE}, 32'd0);
      chk("rst_fd", {31'b0, FRAME_DONE}, 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      // three characters at prescale 32, even parity
      run_frame(32'h0081_02AA, 3, 32, 1'b1, 1'b0, 1'b0, 0, 1'b0, fd);
      chk("fd_cycle_1056", fd, 1056);
      // odd parity, two stop bits
      run_frame(32'h0000_0055, 1, 4, 1'b1, 1'b1, 1'b1, 0, 1'b0, fd);
      chk("fd_cycle_48", fd, 48);
      // prescale 0 behaves as 1, no parity
      run_frame(32'h0000_000F, 1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, fd);
      chk("fd_cycle_10", fd, 10);
      // clamp of oversized length, with a stray request mid-frame
      run_frame(32'hC3A5_1E7B, 7, 2, 1'b1, 1'b0, 1'b1, 0, 1'b1, fd);

      // zero-length request is dropped
      FRAME_LEN = 3'd0; FRAME_VLD = 1'b1;
      @(negedge CLK); FRAME_VLD = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("len0_busy", {31'b0, BUSY}, 32'd0);
         chk("len0_tx", {31'b0, TX_OUT}, 32'd1);
      end

`ifdef UART_FRAME_GEN_GAP_EN
      run_frame(32'h0000_3C96, 2, 8, 1'b0, 1'b0, 1'b0, 2, 1'b0, fd);
      chk("fd_cycle_gap", fd, 176);
`endif

      // reset inside the data bits of byte 1, then an immediate new frame
      FRAME_DATA = 32'h1234_5678; FRAME_LEN = 3'd3; PRESCALE = 6'd4;
      PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; FRAME_VLD = 1'b1;
`ifdef UART_FRAME_GEN_GAP_EN
      GAP_BITS = '0;
`endif
      @(posedge CLK); #1 FRAME_VLD = 1'b0;
      repeat (55) @(negedge CLK);
      chk("pre_rst_busy", {31'b0, BUSY}, 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      chk("mid_rst_tx", {31'b0, TX_OUT}, 32'd1);
      chk("mid_rst_busy", {31'b0, BUSY}, 32'd0);
      chk("mid_rst_bd", {31'b0, BYTE_DONE}, 32'd0);
      chk("mid_rst_fd", {31'b0, FRAME_DONE}, 32'd0);
      RST = 1'b0;
      run_frame(32'h0000_00E1, 1, 3, 1'b1, 1'b1, 1'b0, 0, 1'b0, fd);

      // randomized frames, back-to-back where the previous frame ends
      for (int t = 0; t < 20; t++) begin
         int len;
         len = $urandom_range(0, 7);
         if (len == 0) begin
            FRAME_LEN = 3'd0; FRAME_VLD = 1'b1;
            @(negedge CLK); FRAME_VLD = 1'b0;
            @(negedge CLK);
            chk("rnd_len0_busy", {31'b0, BUSY}, 32'd0);
         end else begin
            run_frame($urandom, len, $urandom_range(0, 6), 1'($urandom), 1'($urandom),
                      1'($urandom), $urandom_range(0, 3), 1'($urandom), fd);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_frame_gen.md
UART_FRAME_GEN -- requirements
Module: uart_frame_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per UART character.
REQ-002 SHALL have parameter MAX_BYTES, default 4, maximum characters per frame.
REQ-003 SHALL have port CLK, input, 1, the single clock.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-005 SHALL have port PRESCALE, input, 6, CLK cycles per bit time.
REQ-006 SHALL have ports PAR_EN, input, 1, parity enable, and PAR_TYP, input, 1, parity type (0 = even, 1 = odd).
REQ-007 SHALL have port STOP2, input, 1, select two stop bits (0 = one stop bit).
REQ-008 SHALL have port FRAME_DATA, input, DATA_WIDTH*MAX_BYTES, frame payload; byte 0 is bits [DATA_WIDTH-1:0].
REQ-009 SHALL have port FRAME_LEN, input, $clog2(MAX_BYTES+1), number of characters to send.
REQ-010 SHALL have port FRAME_VLD, input, 1, frame request strobe.
REQ-011 SHALL have ports TX_OUT, output, 1, serial line; BUSY, output, 1, frame in progress.
REQ-012 SHALL have ports BYTE_DONE, output, 1, and FRAME_DONE, output, 1, single-cycle completion pulses.

Function
REQ-013 SHALL accept a request only when FRAME_VLD=1 and BUSY=0; on acceptance it SHALL capture FRAME_DATA, FRAME_LEN, PRESCALE, PAR_EN, PAR_TYP and STOP2.
REQ-014 SHALL ignore FRAME_VLD while BUSY=1 and SHALL leave the current frame unaffected.
REQ-015 SHALL ignore a request with FRAME_LEN=0 and SHALL keep BUSY low.
REQ-016 SHALL clamp FRAME_LEN values above MAX_BYTES to MAX_BYTES.
REQ-017 SHALL treat a captured PRESCALE of 0 as 1.
REQ-018 SHALL implement the FSM IDLE -> START -> DATA -> PARITY -> STOP -> (START | IDLE).
REQ-019 SHALL skip PARITY when PAR_EN=0.
REQ-020 SHALL raise BUSY and drive TX_OUT=0 (start bit) on the cycle after acceptance.
REQ-021 SHALL hold each bit on TX_OUT for exactly PRESCALE cycles.
REQ-022 SHALL send data bits LSB first.
REQ-023 SHALL compute the parity bit as XOR of the data bits when PAR_TYP=0 and its inverse when PAR_TYP=1.
REQ-024 SHALL drive each stop bit as 1, sending 1 stop bit, or 2 when STOP2=1.
REQ-025 SHALL send characters in order byte 0 .. FRAME_LEN-1, with the start bit of byte n+1 directly after the last stop bit of byte n.
REQ-026 SHALL pulse BYTE_DONE in the final cycle of each character's last stop bit.
REQ-027 SHALL pulse FRAME_DONE coincident with the last BYTE_DONE, then deassert BUSY and return to IDLE on the next cycle.
REQ-028 SHALL be able to accept a new FRAME_VLD in the cycle BUSY is first low.
REQ-029 SHALL hold TX_OUT at 1 in IDLE.

Reset
REQ-030 SHALL, on RST=1 at a CLK edge, including mid-frame, abort the frame, enter IDLE and drive TX_OUT=1, BUSY=0, BYTE_DONE=0, FRAME_DONE=0.
REQ-031 SHALL clear all counters and captured registers on reset.

Configuration
REQ-032 SHALL, with macro UART_FRAME_GEN_GAP_EN defined, add input GAP_BITS (4 bits, captured at acceptance) and insert GAP_BITS idle bit times (TX_OUT=1) between characters, but not after the last character.
REQ-033 SHALL, without UART_FRAME_GEN_GAP_EN, omit the GAP_BITS port and send characters back-to-back per REQ-025.

Verification
REQ-034 SHALL test PRESCALE=32, PAR_EN=1, PAR_TYP=0, frame {0xAA,0x02,0x81}, LEN=3 -> bits 0,01010101,0,1 then 0,01000000,1,1 then 0,10000001,0,1, each 32 cycles; FRAME_DONE at cycle 1056 after acceptance.
REQ-035 SHALL test PAR_TYP=1, STOP2=1, PRESCALE=4, byte 0x55, LEN=1 -> parity bit 1, two stop bits, 48 cycles total, one BYTE_DONE and FRAME_DONE together.
REQ-036 SHALL test PAR_EN=0, PRESCALE=0, byte 0x0F -> 10 bit times of 1 cycle each, no parity bit.
REQ-037 SHALL test FRAME_LEN=0 -> BUSY stays 0 and TX_OUT stays 1; FRAME_VLD pulsed mid-frame -> no change to the output bit stream.
REQ-038 SHALL test RST asserted in the DATA state of byte 1 -> next cycle TX_OUT=1, BUSY=0, and a new frame is accepted immediately after RST deasserts.
REQ-039 SHALL test, with UART_FRAME_GEN_GAP_EN, GAP_BITS=2, PRESCALE=8, LEN=2 -> 16 idle cycles between characters and none after the last.
